// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and constants: requant FSM states, default output
// range and rounding constant, and the accumulator sizing check.
package cnn_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int OUT_W_DEF = 32;
    localparam int SHIFT_DEF = 16;

    localparam logic signed [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    localparam logic signed [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};
    localparam longint RND_CONST = (SHIFT_DEF > 0) ? (longint'(1) << (SHIFT_DEF - 1)) : 64'sd0;

    // The accumulator must hold TERMS products plus a bias without wrapping.
    function automatic bit acc_w_ok(input int acc_w, input int pw, input int terms);
        return (terms >= 1) && (acc_w >= pw + $clog2(terms) + 1);
    endfunction

endpackage

// File: rtl/sat_round.sv
// Combinational round-half-up, arithmetic right shift and saturate to OUT_W.
// Build option ACC_REQUANT_RELU_EN clamps negative results to zero afterwards.
module sat_round #(
    parameter int ACC_W = 72,
    parameter int OUT_W = 32,
    parameter int SHIFT = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] data,
    output logic                    sat
);

    localparam int RW = ACC_W + 1;

    logic signed [RW-1:0] rnd_const;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] q;
    logic signed [RW-1:0] max_w;
    logic signed [RW-1:0] min_w;

    generate
        if (SHIFT > 0) begin : g_rnd
            assign rnd_const = RW'(1) << (SHIFT - 1);
        end else begin : g_no_rnd
            assign rnd_const = '0;
        end
    endgenerate

    // One extra bit so adding the rounding constant cannot overflow.
    assign r     = $signed({acc[ACC_W-1], acc}) + rnd_const;
    assign q     = r >>> SHIFT;
    assign max_w = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    assign min_w = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        sat  = 1'b0;
        data = q[OUT_W-1:0];
        if (q > max_w) begin
            data = max_w[OUT_W-1:0];
            sat  = 1'b1;
        end else if (q < min_w) begin
            data = min_w[OUT_W-1:0];
            sat  = 1'b1;
        end
`ifdef ACC_REQUANT_RELU_EN
        if (data[OUT_W-1]) begin
            data = '0;
            sat  = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/acc_requant.sv
// Accumulates TERMS signed products plus bias per window, then requantises the
// sum via sat_round and holds it on a valid/ready output (option ACC_REQUANT_RELU_EN).
module acc_requant
    import cnn_pkg::*;
#(
    parameter int PW    = 64,
    parameter int ACC_W = 72,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TERMS = 9,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PW-1:0]    in_prod,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    generate
        if (!acc_w_ok(ACC_W, PW, TERMS)) begin : g_bad_cfg
            $error("acc_requant: ACC_W too small for PW and TERMS");
        end
    endgenerate

    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMS - 1);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic                    out_valid_reg, out_valid_next;
    logic signed [OUT_W-1:0] out_data_reg, out_data_next;
    logic                    out_sat_reg, out_sat_next;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [OUT_W-1:0] rq_data;
    logic                    rq_sat;

    assign prod_ext = ACC_W'(in_prod);

    sat_round #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_round (
        .acc  (acc_reg),
        .data (rq_data),
        .sat  (rq_sat)
    );

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        acc_next       = acc_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_sat_next   = out_sat_reg;
        in_ready       = 1'b0;
        case (state_reg)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Bias only enters on the first product of the window.
                    acc_next = (count_reg == '0) ? (bias + prod_ext) : (acc_reg + prod_ext);
                    if (count_reg == LAST) begin
                        count_next = '0;
                        state_next = ROUND;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ROUND: begin
                out_data_next  = rq_data;
                out_sat_next   = rq_sat;
                out_valid_next = 1'b1;
                state_next     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACC;
            count_reg     <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            acc_reg       <= acc_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sat_reg   <= out_sat_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_acc_requant.sv
// Scoreboard bench for acc_requant: expected results are queued when a window
// completes and popped on each output handshake.
module tb_acc_requant;

    localparam int PW    = 64;
    localparam int ACC_W = 72;
    localparam int OUT_W = 32;
    localparam int TERMS = 9;
    localparam int SHIFT = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [PW-1:0]    in_prod = '0;
    logic signed [ACC_W-1:0] bias = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;

    acc_requant #(
        .PW    (PW),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .TERMS (TERMS),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    // Drives n products (p0 first, pr afterwards); queues an expectation when a full window is sent.
    task automatic send_window(input logic signed [71:0] b, input logic signed [63:0] p0,
                               input logic signed [63:0] pr, input int gap_pct, input int n,
                               input logic [31:0] ed, input logic es, input string name);
        int   sent = 0;
        int   budget = 0;
        exp_t e;
        while (sent < n) begin
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                check_val({name, "_timeout"}, 72'd0, 72'd1);
                in_valid = 1'b0;
                return;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_prod  = (sent == 0) ? p0 : pr;
                bias     = (sent == 0) ? b : {8'($urandom), $urandom, $urandom};
                if (in_ready) begin
                    sent++;
                    if (sent == n) begin
                        last_acc = cyc;
                        if (n == TERMS) begin
                            e.data = ed;
                            e.sat  = es;
                            exp_q.push_back(e);
                            $display("window %s: queued data=0x%08h sat=%0d", name, ed, es);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        while (exp_q.size() > 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check_val({name, "_drain"}, 72'(exp_q.size()), 72'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid)
                check_val("latency", 72'(cyc - last_acc), 72'd2);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 72'd1, 72'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("data", {40'h0, out_data}, {40'h0, e.data});
                    check_val("sat", {71'h0, out_sat}, {71'h0, e.sat});
                    $display("out: data=0x%08h sat=%0d", out_data, out_sat);
                end
            end
            prev_valid <= out_valid;
        end
    end

    initial begin
        logic [31:0] held;
        logic [31:0] neg_sat_d;
        logic        neg_sat_s;
        logic [31:0] m1_d;
        logic [31:0] min_d;
        int          bnd;
`ifdef ACC_REQUANT_RELU_EN
        neg_sat_d = 32'h0;
        neg_sat_s = 1'b0;
        m1_d      = 32'h0;
        min_d     = 32'h0;
`else
        neg_sat_d = 32'h80000000;
        neg_sat_s = 1'b1;
        m1_d      = 32'hFFFFFFFF;
        min_d     = 32'h80000000;
`endif
        repeat (3) @(negedge clk);
        check_val("rst_valid", {71'h0, out_valid}, 72'd0);
        check_val("rst_data", {40'h0, out_data}, 72'd0);
        check_val("rst_sat", {71'h0, out_sat}, 72'd0);
        check_val("rst_in_ready", {71'h0, in_ready}, 72'd1);
        rst_n = 1'b1;

        send_window(72'sd0, 64'sd65536, 64'sd65536, 0, TERMS, 32'd9, 1'b0, "nine");
        send_window(72'sd0, 64'sd32768, 64'sd0, 0, TERMS, 32'd1, 1'b0, "rnd_p");
        send_window(72'sd0, -64'sd32768, 64'sd0, 0, TERMS, 32'd0, 1'b0, "rnd_mh");
        send_window(72'sd0, -64'sd32769, 64'sd0, 0, TERMS, m1_d, 1'b0, "rnd_m1");
        send_window(72'sd0, 64'sh4000000000000000, 64'sh4000000000000000, 0, TERMS,
                    32'h7FFFFFFF, 1'b1, "sat_pos");
        send_window(72'sd0, -64'sh4000000000000000, -64'sh4000000000000000, 0, TERMS,
                    neg_sat_d, neg_sat_s, "sat_neg");
        send_window(72'sd0, 64'sh00007FFFFFFF0000, 64'sd0, 0, TERMS, 32'h7FFFFFFF, 1'b0, "edge_max");
        send_window(72'sd0, -64'sh0000800000000000, 64'sd0, 0, TERMS, min_d, 1'b0, "edge_min");
        wait_drain("basic");

        // Backpressure: result must stay put and no product may be taken while held.
        out_ready = 1'b0;
        send_window(72'sd0, 64'sd196608, 64'sd0, 0, TERMS, 32'd3, 1'b0, "bp");
        bnd = 0;
        while (!out_valid && bnd < 50) begin
            @(negedge clk);
            bnd++;
        end
        check_val("bp_valid_seen", {71'h0, out_valid}, 72'd1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_prod  = 64'sd65536;
            check_val("bp_hold_valid", {71'h0, out_valid}, 72'd1);
            check_val("bp_hold_data", {40'h0, out_data}, {40'h0, held});
            check_val("bp_in_ready", {71'h0, in_ready}, 72'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_ready_after_hs", {71'h0, in_ready}, 72'd1);
        wait_drain("bp");

        send_window(-72'sd327680, 64'sd65536, 64'sd65536, 30, TERMS, 32'd4, 1'b0, "bias_gap");
        wait_drain("bias_gap");

        // Reset partway through a window; the partial sum must be discarded.
        send_window(72'sd0, 64'sd65536, 64'sd65536, 0, 4, 32'd0, 1'b0, "partial");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {71'h0, out_valid}, 72'd0);
        check_val("mid_rst_data", {40'h0, out_data}, 72'd0);
        check_val("mid_rst_sat", {71'h0, out_sat}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("mid_rst_in_ready", {71'h0, in_ready}, 72'd1);
        send_window(72'sd0, 64'sd65536, 64'sd65536, 0, TERMS, 32'd9, 1'b0, "post_rst");
        wait_drain("post_rst");

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
